// File: rtl/or1200_sstk_checker_pkg.sv
// Shared types and constants for the OR1200 shadow-stack checker.
// Holds the checker state encoding and the violation codes reported to the exception unit.
package or1200_sstk_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_VIOL = 2'd2
  } sstk_state_e;

  localparam logic [1:0] SSTK_VIOL_NONE      = 2'b00;
  localparam logic [1:0] SSTK_VIOL_MISMATCH  = 2'b01;
  localparam logic [1:0] SSTK_VIOL_OVERFLOW  = 2'b10;
  localparam logic [1:0] SSTK_VIOL_UNDERFLOW = 2'b11;

endpackage

// File: rtl/or1200_sstk_ram.sv
// Shadow-stack storage: DEPTH x DW, one write port and one synchronous read port.
// Read data appears one cycle after re; contents are never reset.
module or1200_sstk_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/or1200_sstk_checker.sv
// Shadow-stack checker: pushes return addresses, pops and compares against the real
// return target, and raises a held violation on mismatch, overflow or underflow.
module or1200_sstk_checker
  import or1200_sstk_checker_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  // Handshake: a request transfers in the cycle where valid and ready are both high;
  // ready never depends on the same request's data, and pop wins when both are valid.
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_addr,
  input  logic          pop_valid,
  output logic          pop_ready,
  input  logic [DW-1:0] pop_target,
  output logic          chk_done,
  output logic          chk_match,
  output logic          viol_req,
  input  logic          viol_ack,
  output logic [1:0]    viol_code,
  output logic [DW-1:0] viol_addr,
  output logic [AW:0]   depth_o,
  output sstk_state_e   dbg_state
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  sstk_state_e   state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic          chk_done_q, chk_done_d;
  logic          chk_match_q, chk_match_d;
  logic          viol_req_q, viol_req_d;
  logic [1:0]    viol_code_q, viol_code_d;
  logic [DW-1:0] viol_addr_q, viol_addr_d;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          push_fire, pop_fire, entry_match;

  assign pop_ready  = (state_q == ST_IDLE);
  assign push_ready = (state_q == ST_IDLE) && !pop_valid;
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  // Top-of-stack is one below the count; index arithmetic wraps within AW bits.
  assign ram_waddr   = count_q[AW-1:0];
  assign ram_raddr   = count_q[AW-1:0] - AW'(1);
  assign entry_match = (ram_rdata == tgt_q);

  or1200_sstk_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (push_addr),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tgt_d       = tgt_q;
    chk_done_d  = 1'b0;
    chk_match_d = 1'b0;
    viol_req_d  = viol_req_q;
    viol_code_d = viol_code_q;
    viol_addr_d = viol_addr_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    if (flush) begin
      // Context switch: drop the stack, any check in flight and any pending violation.
      state_d     = ST_IDLE;
      count_d     = '0;
      viol_req_d  = 1'b0;
      viol_code_d = SSTK_VIOL_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop_fire) begin
            if (count_q == '0) begin
              state_d     = ST_VIOL;
              viol_req_d  = 1'b1;
              viol_code_d = SSTK_VIOL_UNDERFLOW;
              viol_addr_d = pop_target;
            end else begin
              ram_re  = 1'b1;
              count_d = count_q - 1'b1;
              tgt_d   = pop_target;
              state_d = ST_RD;
            end
          end else if (push_fire) begin
            if (count_q == FULL) begin
              state_d     = ST_VIOL;
              viol_req_d  = 1'b1;
              viol_code_d = SSTK_VIOL_OVERFLOW;
              viol_addr_d = push_addr;
            end else begin
              ram_we  = 1'b1;
              count_d = count_q + 1'b1;
            end
          end
        end
        ST_RD: begin
          chk_done_d  = 1'b1;
          chk_match_d = entry_match;
          if (entry_match) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_VIOL;
            viol_req_d  = 1'b1;
            viol_code_d = SSTK_VIOL_MISMATCH;
            viol_addr_d = ram_rdata;
          end
        end
        ST_VIOL: begin
          if (viol_ack) begin
            state_d     = ST_IDLE;
            viol_req_d  = 1'b0;
            viol_code_d = SSTK_VIOL_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      tgt_q       <= '0;
      chk_done_q  <= 1'b0;
      chk_match_q <= 1'b0;
      viol_req_q  <= 1'b0;
      viol_code_q <= SSTK_VIOL_NONE;
      viol_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tgt_q       <= tgt_d;
      chk_done_q  <= chk_done_d;
      chk_match_q <= chk_match_d;
      viol_req_q  <= viol_req_d;
      viol_code_q <= viol_code_d;
      viol_addr_q <= viol_addr_d;
    end
  end

  assign chk_done  = chk_done_q;
  assign chk_match = chk_match_q;
  assign viol_req  = viol_req_q;
  assign viol_code = viol_code_q;
  assign viol_addr = viol_addr_q;
  assign depth_o   = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_or1200_sstk_checker.sv
// Bench for or1200_sstk_checker (DEPTH=4 build): directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the shadow stack.
module tb_or1200_sstk_checker;
  import or1200_sstk_checker_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_addr = '0;
  logic          pop_valid = 1'b0;
  logic          pop_ready;
  logic [DW-1:0] pop_target = '0;
  logic          chk_done, chk_match, viol_req;
  logic          viol_ack = 1'b0;
  logic [1:0]    viol_code;
  logic [DW-1:0] viol_addr;
  logic [AW:0]   depth_o;
  sstk_state_e   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: the stack contents plus the visible protocol status.
  logic [DW-1:0] exp_q[$];
  bit            m_checking = 1'b0;
  bit            m_viol = 1'b0;
  logic [1:0]    m_code = 2'b00;
  logic [DW-1:0] m_addr = '0;
  bit            m_done = 1'b0;
  bit            m_match = 1'b0;
  logic [DW-1:0] m_popped = '0;
  logic [DW-1:0] m_tgt = '0;

  or1200_sstk_checker #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_addr  (push_addr),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_target (pop_target),
    .chk_done   (chk_done),
    .chk_match  (chk_match),
    .viol_req   (viol_req),
    .viol_ack   (viol_ack),
    .viol_code  (viol_code),
    .viol_addr  (viol_addr),
    .depth_o    (depth_o),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs presented in that cycle.
  task automatic model_edge();
    if (rst) begin
      exp_q.delete();
      m_checking = 0; m_viol = 0; m_code = 2'b00; m_addr = '0; m_done = 0; m_match = 0;
    end else if (flush) begin
      exp_q.delete();
      m_checking = 0; m_viol = 0; m_code = 2'b00; m_done = 0;
    end else begin
      m_done = 0;
      if (m_viol) begin
        if (viol_ack) begin m_viol = 0; m_code = 2'b00; end
      end else if (m_checking) begin
        m_checking = 0;
        m_done     = 1;
        m_match    = (m_popped == m_tgt);
        if (!m_match) begin m_viol = 1; m_code = 2'b01; m_addr = m_popped; end
      end else if (pop_valid) begin
        if (exp_q.size() == 0) begin
          m_viol = 1; m_code = 2'b11; m_addr = pop_target;
        end else begin
          m_popped = exp_q.pop_back();
          m_tgt = pop_target;
          m_checking = 1;
        end
      end else if (push_valid) begin
        if (exp_q.size() == DEPTH) begin
          m_viol = 1; m_code = 2'b10; m_addr = push_addr;
        end else begin
          exp_q.push_back(push_addr);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Driver: present one cycle of inputs, then advance past the edge.
  task automatic drive(input logic pv, input logic [31:0] pa, input logic ov,
                       input logic [31:0] ot, input logic fl, input logic ak);
    push_valid = pv; push_addr = pa; pop_valid = ov; pop_target = ot;
    flush = fl; viol_ack = ak;
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard compare on the falling edge, every cycle after the first reset.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pop_ready", {31'd0, pop_ready}, {31'd0, !m_checking && !m_viol});
      chk("push_ready", {31'd0, push_ready}, {31'd0, !m_checking && !m_viol && !pop_valid});
      chk("depth_o", 32'(depth_o), 32'(exp_q.size()));
      chk("chk_done", {31'd0, chk_done}, {31'd0, m_done});
      if (m_done) chk("chk_match", {31'd0, chk_match}, {31'd0, m_match});
      chk("viol_req", {31'd0, viol_req}, {31'd0, m_viol});
      chk("viol_code", {30'd0, viol_code}, {30'd0, m_code});
      if (m_viol) chk("viol_addr", viol_addr, m_addr);
    end
  end

  initial begin
    logic pv, ov, fl, ak;
    logic [31:0] pa, ot;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_depth", 32'(depth_o), 0);
    chk("rst_viol_req", {31'd0, viol_req}, 0);
    chk("rst_viol_code", {30'd0, viol_code}, 0);
    chk("rst_pop_ready", {31'd0, pop_ready}, 1);
    chk("rst_push_ready", {31'd0, push_ready}, 1);

    // Matching return
    drive(1, 32'h1000, 0, 0, 0, 0);
    drive(1, 32'h2000, 0, 0, 0, 0);
    chk("lit_depth2", 32'(depth_o), 2);
    drive(0, 0, 1, 32'h2000, 0, 0);
    chk("lit_depth1", 32'(depth_o), 1);
    idle();
    chk("lit_done", {31'd0, chk_done}, 1);
    chk("lit_match", {31'd0, chk_match}, 1);
    chk("lit_no_viol", {31'd0, viol_req}, 0);
    idle();
    chk("lit_done_pulse", {31'd0, chk_done}, 0);

    // Mismatch, held violation, acknowledge
    drive(1, 32'h3000, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h3004, 0, 0);
    idle();
    chk("lit_mm_done", {31'd0, chk_done}, 1);
    chk("lit_mm_match", {31'd0, chk_match}, 0);
    chk("lit_mm_code", {30'd0, viol_code}, 32'h1);
    chk("lit_mm_addr", viol_addr, 32'h3000);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("lit_mm_held", {31'd0, viol_req}, 1);
    end
    drive(0, 0, 0, 0, 0, 1);
    chk("lit_ack_req", {31'd0, viol_req}, 0);
    chk("lit_ack_ready", {31'd0, pop_ready}, 1);

    // Simultaneous push and pop: pop wins
    push_valid = 1; push_addr = 32'h5000; pop_valid = 1; pop_target = 32'h1000;
    flush = 0; viol_ack = 0;
    #2;
    chk("lit_both_push_ready", {31'd0, push_ready}, 0);
    chk("lit_both_pop_ready", {31'd0, pop_ready}, 1);
    tick();
    idle();
    chk("lit_both_match", {31'd0, chk_match}, 1);
    drive(1, 32'h5000, 0, 0, 0, 0);
    chk("lit_both_depth", 32'(depth_o), 1);

    // Overflow
    drive(0, 0, 0, 0, 1, 0);
    chk("lit_flush_depth", 32'(depth_o), 0);
    for (int i = 0; i < DEPTH; i++) drive(1, 32'h100 + 32'(i) * 32'h10, 0, 0, 0, 0);
    chk("lit_full", 32'(depth_o), 4);
    drive(1, 32'hDEAD, 0, 0, 0, 0);
    chk("lit_ovf_code", {30'd0, viol_code}, 32'h2);
    chk("lit_ovf_addr", viol_addr, 32'hDEAD);
    chk("lit_ovf_depth", 32'(depth_o), 4);
    drive(0, 0, 0, 0, 0, 1);

    // Underflow
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 32'h44, 0, 0);
    chk("lit_unf_code", {30'd0, viol_code}, 32'h3);
    chk("lit_unf_addr", viol_addr, 32'h44);
    chk("lit_unf_done", {31'd0, chk_done}, 0);
    idle();
    chk("lit_unf_done2", {31'd0, chk_done}, 0);
    drive(0, 0, 0, 0, 0, 1);

    // Flush while a mismatch violation is pending
    for (int i = 0; i < 3; i++) drive(1, 32'h700 + 32'(i), 0, 0, 0, 0);
    drive(0, 0, 1, 32'h1, 0, 0);
    idle();
    chk("lit_fl_viol", {31'd0, viol_req}, 1);
    drive(0, 0, 0, 0, 1, 0);
    chk("lit_fl_depth", 32'(depth_o), 0);
    chk("lit_fl_req", {31'd0, viol_req}, 0);
    drive(0, 0, 1, 32'h77, 0, 0);
    chk("lit_fl_unf", {30'd0, viol_code}, 32'h3);
    drive(0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      pv = 1'($urandom_range(0, 1));
      pa = $urandom;
      ov = ($urandom_range(0, 9) < 3);
      ot = (exp_q.size() > 0 && $urandom_range(0, 3) != 0) ? exp_q[$] : $urandom;
      fl = ($urandom_range(0, 63) == 0);
      ak = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 499) == 0);
      drive(pv, pa, ov, ot, fl, ak);
    end
    rst = 1'b0;
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
